// File: rtl/input_packet_tx.sv
// Button-to-packet transmitter: synchronizes and debounces five buttons, resolves a
// direction with auto-repeat, and emits single-beat 64-bit AXI-Stream event packets.
module input_packet_tx #(
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          REPEAT_CYCLES   = 5000000,
  parameter logic [7:0]  PKT_TYPE        = 8'h01
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_btn_up,
  input  logic        i_btn_down,
  input  logic        i_btn_left,
  input  logic        i_btn_right,
  input  logic        i_btn_fire,
  output logic [63:0] o_m_axis_tdata,
  output logic        o_m_axis_tvalid,
  output logic        o_m_axis_tlast,
  input  logic        i_m_axis_tready,
  output logic        o_busy
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  // Bit order everywhere: {fire, right, left, down, up}
  logic [4:0]      btn_raw;
  logic [4:0]      sync_p0;
  logic [4:0]      sync_p1;
  logic [4:0]      deb;
  logic [DB_W-1:0] db_cnt [5];

  logic [2:0]      dir;
  logic [2:0]      dir_q;
  logic            dir_change;
  logic            fire_q;
  logic            fire_rise;
  logic [RP_W-1:0] rpt_cnt;
  logic            rpt_tick;
  logic            move_pending;
  logic            move_req;
  logic            fire_pending;

  state_t          state;
  state_t          next_state;
  logic            load;
  logic            handshake;
  logic [7:0]      seq;
  logic [63:0]     tdata;

  assign btn_raw = {i_btn_fire, i_btn_right, i_btn_left, i_btn_down, i_btn_up};

  // Stage p0/p1: two-flop synchronizer
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: the synchronized level must disagree for DEBOUNCE_CYCLES edges in a row
  for (genvar g = 0; g < 5; g++) begin : g_deb
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        db_cnt[g] <= '0;
        deb[g]    <= 1'b0;
      end else if (sync_p1[g] == deb[g]) begin
        db_cnt[g] <= '0;
      end else if (db_cnt[g] == DB_LAST) begin
        db_cnt[g] <= '0;
        deb[g]    <= sync_p1[g];
      end else begin
        db_cnt[g] <= db_cnt[g] + 1'b1;
      end
    end
  end

  always_comb begin
    dir = 3'd0;
    if      (deb[0]) dir = 3'd1;
    else if (deb[1]) dir = 3'd2;
    else if (deb[2]) dir = 3'd3;
    else if (deb[3]) dir = 3'd4;
  end

  assign dir_change = (dir != dir_q);
  assign rpt_tick   = (dir != 3'd0) && !dir_change && (rpt_cnt == RP_LAST);
  assign fire_rise  = deb[4] && !fire_q;
  // A pending move only counts while a direction is still held this cycle
  assign move_req   = move_pending && (dir != 3'd0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dir_q   <= 3'd0;
      fire_q  <= 1'b0;
      rpt_cnt <= '0;
    end else begin
      dir_q  <= dir;
      fire_q <= deb[4];
      if (dir == 3'd0 || dir_change || rpt_cnt == RP_LAST) rpt_cnt <= '0;
      else                                                 rpt_cnt <= rpt_cnt + 1'b1;
    end
  end

  // New events win over the load-cycle clear so nothing arriving then is lost
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      move_pending <= 1'b0;
      fire_pending <= 1'b0;
    end else begin
      if (dir == 3'd0)                          move_pending <= 1'b0;
      else if ((dir_change) || rpt_tick)        move_pending <= 1'b1;
      else if (load)                            move_pending <= 1'b0;

      if (fire_rise)  fire_pending <= 1'b1;
      else if (load)  fire_pending <= 1'b0;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (move_req || fire_pending) begin
          next_state = SEND;
          load       = 1'b1;
        end
      end
      SEND: begin
        if (i_m_axis_tready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign handshake = (state == SEND) && i_m_axis_tready;

  // Stage p2: packet register and sequence number
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      seq   <= 8'd0;
      tdata <= 64'd0;
    end else begin
      state <= next_state;
      if (load) begin
        tdata <= {32'd0, seq, 7'd0, fire_pending, 5'd0,
                  (move_req ? dir : 3'd0), PKT_TYPE};
      end
      if (handshake) seq <= seq + 8'd1;
    end
  end

  assign o_m_axis_tdata  = tdata;
  assign o_m_axis_tvalid = (state == SEND);
  assign o_m_axis_tlast  = (state == SEND);
  assign o_busy          = (state == SEND);

endmodule

// File: doc/input_packet_tx.md
INPUT_PACKET_TX -- requirements
Module: input_packet_tx

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, meaning cycles a synchronized button level must hold before the debounced state changes (10 ms at 100 MHz).
REQ-002 Parameter REPEAT_CYCLES, default 5000000, meaning cycles between repeated move packets while a direction is held.
REQ-003 Parameter PKT_TYPE, default 8'h01, meaning the value placed in byte 0 of every packet.
REQ-004 Port i_clk, input, 1, meaning the single clock; all logic is in this clock domain.
REQ-005 Port i_rst, input, 1, meaning asynchronous active-high reset.
REQ-006 Ports i_btn_up, i_btn_down, i_btn_left, i_btn_right, i_btn_fire, input, 1 each, meaning raw asynchronous active-high buttons.
REQ-007 Port o_m_axis_tdata, output, 64, meaning packet data.
REQ-008 Port o_m_axis_tvalid, output, 1, meaning packet valid.
REQ-009 Port o_m_axis_tlast, output, 1, meaning end of packet; it equals o_m_axis_tvalid because every packet is one beat.
REQ-010 Port i_m_axis_tready, input, 1, meaning the sink accepts the beat.
REQ-011 Port o_busy, output, 1, meaning a packet is being offered; it equals o_m_axis_tvalid.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer and then its own debouncer.
REQ-013 Debouncer: counter clears whenever the synchronized level equals the debounced state; otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, the debounced state takes the synchronized level and the counter clears.
REQ-014 Resolved direction dir, combinational from debounced states, priority up=1 > down=2 > left=3 > right=4, 0 if none held.
REQ-015 Repeat counter: clears on any change of dir or when dir=0; otherwise increments; at REPEAT_CYCLES-1 it wraps to 0 and sets move_pending.
REQ-016 A change of dir to a nonzero value SHALL set move_pending in the same cycle.
REQ-017 move_pending SHALL clear when dir becomes 0, so no stale move is sent after release.
REQ-018 A debounced rising edge of fire SHALL set fire_pending; further edges while it is set merge into that one request.
REQ-019 FSM states IDLE and SEND; reset state IDLE.
REQ-020 IDLE -> SEND when move_pending or fire_pending is set.
REQ-021 On that IDLE -> SEND transition, the block SHALL load the packet fields:
- byte0 = PKT_TYPE;
- byte1 = dir if move_pending, else 0;
- byte2 = 1 if fire_pending, else 0;
- byte3 = seq;
- bytes 4-7 = 0.
REQ-022 On the same transition, both pendings clear and o_m_axis_tvalid rises on the next edge.
REQ-023 An event arriving in the load cycle SHALL remain pending for the next packet.
REQ-024 In SEND, o_m_axis_tdata and tvalid SHALL hold stable until i_m_axis_tready=1.
REQ-025 On the handshake: tvalid falls, seq increments modulo 256, and the FSM returns to IDLE.
REQ-026 Minimum packet spacing is 2 cycles.
REQ-027 Events during SEND SHALL set or merge pendings and are never lost; direction is sampled only at load time.
REQ-028 tready while tvalid=0 SHALL be ignored.

Reset
REQ-029 While i_rst=1, asynchronously and independent of i_clk:
- tvalid, tlast, o_busy and tdata = 0;
- FSM = IDLE;
- seq, pendings, all counters, synchronizer flops and debounced states = 0.
REQ-030 Reset asserted mid-SEND SHALL drop tvalid immediately and discard the packet; after release, no packet is emitted until a new debounced event occurs.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16, PKT_TYPE=8'h01)
V1 Hold i_btn_up, tready=1 -> one beat after debounce with tdata=64'h0000_0000_0000_0101, tlast=1; repeats every 16 cycles with byte3 = 1, 2, ...; no packets after release.
V2 Press fire once with no direction held -> exactly one packet, tdata=64'h0000_0000_0001_0001.
V3 Hold left, press fire within the same cycle window, tready=0 for 10 cycles -> tdata stable for all 10 cycles with byte1=3 and byte2=1; seq increments only on acceptance.
V4 Glitch i_btn_down for 2 cycles -> no packet; up and right held together -> byte1=1.
V5 Three fire pulses during a stalled SEND -> exactly one further packet with byte2=1.
V6 Assert i_rst while tvalid=1 -> tvalid=0 in the same cycle; after release with no buttons held -> no output, first later packet has byte3=0.
